// File: rtl/scm_pkg.sv
// scm_pkg: shared constants and types for the multi-channel statistics module.
//   - MD field bit positions
//   - configuration-chain type codes and per-channel register offsets
//   - channel state encoding
package scm_pkg;

    // MD field positions
    localparam int MD_TS_LSB      = 0;    // [31:0]   timestamp
    localparam int MD_PROTO_LSB   = 72;   // [79:72]  protocol
    localparam int MD_ID_LSB      = 80;   // [87:80]  module ID
    localparam int MD_LEN_LSB     = 96;   // [107:96] length in bytes
    localparam int MD_DISCARD_BIT = 108;  // [108]    discard

    // Configuration chain codes
    localparam logic [2:0] CFG_WR  = 3'b010;
    localparam logic [2:0] CFG_RD  = 3'b001;
    localparam logic [3:0] CFG_RSP = 4'b1011;

    // Per-channel register offsets
    localparam logic [3:0] OFF_PROTO    = 4'h0;
    localparam logic [3:0] OFF_CTRL     = 4'h1;
    localparam logic [3:0] OFF_NRTT     = 4'h2;
    localparam logic [3:0] OFF_BYTES_LO = 4'h8;
    localparam logic [3:0] OFF_BYTES_HI = 4'h9;
    localparam logic [3:0] OFF_PKTS_LO  = 4'hA;
    localparam logic [3:0] OFF_PKTS_HI  = 4'hB;
    localparam logic [3:0] OFF_TIME_LO  = 4'hC;
    localparam logic [3:0] OFF_TIME_HI  = 4'hD;
    localparam logic [3:0] OFF_STATUS   = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_WINDOW = 2'd2,
        ST_DONE   = 2'd3
    } ch_state_t;

endpackage

// File: rtl/scm_ch_stat.sv
// scm_ch_stat: one statistics channel -- configuration registers, the
// IDLE/COUNT/WINDOW/DONE state machine and saturating byte/packet/time counters.
//   pop                 a pair leaves the FIFOs this cycle
//   md_id/proto/len/ts  fields of the popped MD word
//   sent_start/sent_end global start/end pulses
//   cfg_wr/off/wdata    decoded configuration write for this channel
//   discard_hit         this channel counts the pair and is in discard mode
//   bytes/pkts/time_cnt counter values
//   status              {enable, 1'b0, state}
module scm_ch_stat
    import scm_pkg::*;
#(
    parameter int         CNT_W = 64,
    parameter logic [7:0] LMID  = 8'd7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pop,
    input  logic [7:0]        md_id,
    input  logic [7:0]        md_proto,
    input  logic [11:0]       md_len,
    input  logic [31:0]       md_ts,
    input  logic              sent_start,
    input  logic              sent_end,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_off,
    input  logic [31:0]       cfg_wdata,
    output logic              discard_hit,
    output logic [CNT_W-1:0]  bytes_cnt,
    output logic [CNT_W-1:0]  pkts_cnt,
    output logic [CNT_W-1:0]  time_cnt,
    output logic [3:0]        status
);
    ch_state_t   state;
    logic        enable;
    logic        discard;
    logic [7:0]  proto;
    logic [31:0] n_rtt;
    logic [31:0] last_ts;
    logic [31:0] end_time;
    logic        seen;

    logic        eligible;
    logic        in_window;
    logic        count_hit;
    logic        clear;
    logic [31:0] time_inc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [31:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W + 1 - 32){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_comb begin
        eligible  = pop && (md_id == LMID) && enable && (md_proto == proto);
        in_window = (md_ts - end_time) < n_rtt;
        count_hit = 1'b0;
        case (state)
            ST_COUNT:  count_hit = eligible;
            ST_WINDOW: count_hit = eligible && in_window;
            default:   count_hit = 1'b0;
        endcase
        discard_hit = count_hit && discard;
        clear       = cfg_wr && (cfg_off == OFF_CTRL) && cfg_wdata[2];
        time_inc    = seen ? (md_ts - last_ts) : '0;
    end

    assign status = {enable, 1'b0, state};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            enable    <= 1'b0;
            discard   <= 1'b0;
            proto     <= '0;
            n_rtt     <= '0;
            last_ts   <= '0;
            end_time  <= '0;
            seen      <= 1'b0;
            bytes_cnt <= '0;
            pkts_cnt  <= '0;
            time_cnt  <= '0;
        end else begin
            if (cfg_wr) begin
                case (cfg_off)
                    OFF_PROTO: proto <= cfg_wdata[7:0];
                    OFF_CTRL: begin
                        enable  <= cfg_wdata[0];
                        discard <= cfg_wdata[1];
                    end
                    OFF_NRTT:  n_rtt <= cfg_wdata;
                    default:   ;
                endcase
            end

            if (clear) begin
                state     <= ST_IDLE;
                last_ts   <= '0;
                end_time  <= '0;
                seen      <= 1'b0;
                bytes_cnt <= '0;
                pkts_cnt  <= '0;
                time_cnt  <= '0;
            end else begin
                if (count_hit) begin
                    bytes_cnt <= sat_add(bytes_cnt, {20'd0, md_len});
                    pkts_cnt  <= sat_add(pkts_cnt, 32'd1);
                    time_cnt  <= sat_add(time_cnt, time_inc);
                    last_ts   <= md_ts;
                    seen      <= 1'b1;
                end
                case (state)
                    ST_IDLE:   if (sent_start && enable) state <= ST_COUNT;
                    ST_COUNT: begin
                        if (sent_end) begin
                            state <= ST_WINDOW;
                            // a pair counted alongside sent_end is the true last one
                            end_time <= count_hit ? md_ts : last_ts;
                        end
                    end
                    ST_WINDOW: if (eligible && !in_window) state <= ST_DONE;
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: rtl/scm_fifo.sv
// scm_fifo: first-word-fall-through FIFO standing in for the fifo_256_256 /
// fifo_1024_256 IP, sized by AW.
//   clk, rst_n  clock, async active-low reset (pointers and level only)
//   wr, din     write strobe and data (ignored when full)
//   rd          pop the head word (ignored when empty)
//   dout        head word, valid whenever empty is 0
//   empty       no words stored
//   used        number of stored words (0 .. 2^AW)
module scm_fifo #(
    parameter int W  = 256,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [W-1:0]  din,
    input  logic          rd,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [AW:0]   used
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push;
    logic          pull;

    assign empty = (used == '0);
    assign push  = wr && !used[AW];
    assign pull  = rd && !empty;
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            used <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pull) rptr <= rptr + 1'b1;
            case ({push, pull})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/scm_mc.sv
// scm_mc: multi-channel statistics stage on the MD/PHV pipeline.
//   in_md/in_md_wr, in_phv/in_phv_wr    pair input from GME
//   out_md_alf, out_phv_alf             almost-full back to GME
//   out_md/out_md_wr, out_phv/out_phv_wr pair output to next module
//   in_md_alf, in_phv_alf               almost-full from next module
//   sent_start, sent_end                global window pulses
//   cin_*/cout_*                        134-bit configuration chain
module scm_mc
    import scm_pkg::*;
#(
    parameter int          MD_W       = 256,
    parameter int          PHV_W      = 1024,
    parameter int          FIFO_AW    = 8,
    parameter int          ALF_MARGIN = 6,
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 64,
    parameter logic [7:0]  LMID       = 8'd7,
    parameter logic [7:0]  NMID       = 8'd5,
    parameter logic [31:0] CFG_BASE   = 32'h7000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MD_W-1:0]   in_md,
    input  logic              in_md_wr,
    output logic              out_md_alf,
    input  logic [PHV_W-1:0]  in_phv,
    input  logic              in_phv_wr,
    output logic              out_phv_alf,
    output logic [MD_W-1:0]   out_md,
    output logic              out_md_wr,
    input  logic              in_md_alf,
    output logic [PHV_W-1:0]  out_phv,
    output logic              out_phv_wr,
    input  logic              in_phv_alf,
    input  logic              sent_start,
    input  logic              sent_end,
    input  logic [133:0]      cin_data,
    input  logic              cin_data_wr,
    output logic              cout_ready,
    output logic [133:0]      cout_data,
    output logic              cout_data_wr,
    input  logic              cin_ready
);
    localparam int             ALF_LEVEL_I = (1 << FIFO_AW) - ALF_MARGIN;
    localparam logic [FIFO_AW:0] ALF_LEVEL = ALF_LEVEL_I[FIFO_AW:0];
    localparam logic [31:0]    CFG_SPAN    = 32'(16 * NUM_CH);

    logic [MD_W-1:0]  md_head;
    logic [PHV_W-1:0] phv_head;
    logic             md_empty;
    logic             phv_empty;
    logic [FIFO_AW:0] md_used;
    logic [FIFO_AW:0] phv_used;
    logic             pop;
    logic [MD_W-1:0]  fwd_md;
    logic [NUM_CH-1:0] discard_hits;

    scm_fifo #(.W(MD_W), .AW(FIFO_AW)) u_md_fifo (
        .clk(clk), .rst_n(rst_n), .wr(in_md_wr), .din(in_md), .rd(pop),
        .dout(md_head), .empty(md_empty), .used(md_used)
    );

    scm_fifo #(.W(PHV_W), .AW(FIFO_AW)) u_phv_fifo (
        .clk(clk), .rst_n(rst_n), .wr(in_phv_wr), .din(in_phv), .rd(pop),
        .dout(phv_head), .empty(phv_empty), .used(phv_used)
    );

    assign out_md_alf  = in_md_alf  || (md_used  > ALF_LEVEL);
    assign out_phv_alf = in_phv_alf || (phv_used > ALF_LEVEL);
    assign pop = !md_empty && !phv_empty && !in_md_alf && !in_phv_alf;

    always_comb begin
        fwd_md = md_head;
        if (md_head[MD_ID_LSB +: 8] == LMID) fwd_md[MD_ID_LSB +: 8] = NMID;
        if (|discard_hits) fwd_md[MD_DISCARD_BIT] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_md     <= '0;
            out_phv    <= '0;
            out_md_wr  <= 1'b0;
            out_phv_wr <= 1'b0;
        end else begin
            out_md_wr  <= pop;
            out_phv_wr <= pop;
            if (pop) begin
                out_md  <= fwd_md;
                out_phv <= phv_head;
            end
        end
    end

    // Configuration decode
    logic        cfg_acc;
    logic [31:0] cfg_rel;
    logic        cfg_hit;
    logic [2:0]  cfg_ch;
    logic [3:0]  cfg_off;
    logic        cfg_wr_en;
    logic        cfg_rd_en;

    assign cout_ready = cin_ready;
    assign cfg_acc    = cin_data_wr && cin_ready;
    assign cfg_rel    = cin_data[95:64] - CFG_BASE;
    assign cfg_hit    = cfg_rel < CFG_SPAN;
    assign cfg_ch     = cfg_rel[6:4];
    assign cfg_off    = cfg_rel[3:0];
    assign cfg_wr_en  = cfg_acc && cfg_hit && (cin_data[126:124] == CFG_WR)
                        && (cfg_off <= OFF_NRTT);
    assign cfg_rd_en  = cfg_acc && cfg_hit && (cin_data[126:124] == CFG_RD)
                        && (cfg_off >= OFF_BYTES_LO) && (cfg_off <= OFF_STATUS);

    logic [CNT_W-1:0] bytes_arr [NUM_CH];
    logic [CNT_W-1:0] pkts_arr  [NUM_CH];
    logic [CNT_W-1:0] time_arr  [NUM_CH];
    logic [3:0]       status_arr[NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        scm_ch_stat #(.CNT_W(CNT_W), .LMID(LMID)) u_ch (
            .clk(clk),
            .rst_n(rst_n),
            .pop(pop),
            .md_id(md_head[MD_ID_LSB +: 8]),
            .md_proto(md_head[MD_PROTO_LSB +: 8]),
            .md_len(md_head[MD_LEN_LSB +: 12]),
            .md_ts(md_head[MD_TS_LSB +: 32]),
            .sent_start(sent_start),
            .sent_end(sent_end),
            .cfg_wr(cfg_wr_en && (cfg_ch == 3'(c))),
            .cfg_off(cfg_off),
            .cfg_wdata(cin_data[31:0]),
            .discard_hit(discard_hits[c]),
            .bytes_cnt(bytes_arr[c]),
            .pkts_cnt(pkts_arr[c]),
            .time_cnt(time_arr[c]),
            .status(status_arr[c])
        );
    end

    logic [63:0] sel_bytes;
    logic [63:0] sel_pkts;
    logic [63:0] sel_time;
    logic [3:0]  sel_status;
    logic [31:0] rd_val;

    always_comb begin
        sel_bytes  = '0;
        sel_pkts   = '0;
        sel_time   = '0;
        sel_status = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (cfg_ch == c[2:0]) begin
                sel_bytes  = 64'(bytes_arr[c]);
                sel_pkts   = 64'(pkts_arr[c]);
                sel_time   = 64'(time_arr[c]);
                sel_status = status_arr[c];
            end
        end
        case (cfg_off)
            OFF_BYTES_LO: rd_val = sel_bytes[31:0];
            OFF_BYTES_HI: rd_val = sel_bytes[63:32];
            OFF_PKTS_LO:  rd_val = sel_pkts[31:0];
            OFF_PKTS_HI:  rd_val = sel_pkts[63:32];
            OFF_TIME_LO:  rd_val = sel_time[31:0];
            OFF_TIME_HI:  rd_val = sel_time[63:32];
            OFF_STATUS:   rd_val = {28'd0, sel_status};
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_data    <= '0;
            cout_data_wr <= 1'b0;
        end else if (cfg_acc) begin
            if (cfg_rd_en) begin
                cout_data    <= {cin_data[133:128], CFG_RSP, cin_data[123:32], rd_val};
                cout_data_wr <= 1'b1;
            end else if (cfg_wr_en) begin
                cout_data_wr <= 1'b0;
            end else begin
                cout_data    <= cin_data;
                cout_data_wr <= 1'b1;
            end
        end else begin
            cout_data_wr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scm_mc.sv
// tb_scm_mc: directed, table-driven bench for scm_mc (FIFO_AW=4, CNT_W=33).
module tb_scm_mc;

    logic           clk;
    logic           rst_n;
    logic [255:0]   in_md;
    logic           in_md_wr;
    logic           out_md_alf;
    logic [1023:0]  in_phv;
    logic           in_phv_wr;
    logic           out_phv_alf;
    logic [255:0]   out_md;
    logic           out_md_wr;
    logic           in_md_alf;
    logic [1023:0]  out_phv;
    logic           out_phv_wr;
    logic           in_phv_alf;
    logic           sent_start;
    logic           sent_end;
    logic [133:0]   cin_data;
    logic           cin_data_wr;
    logic           cout_ready;
    logic [133:0]   cout_data;
    logic           cout_data_wr;
    logic           cin_ready;

    scm_mc #(
        .MD_W(256), .PHV_W(1024), .FIFO_AW(4), .ALF_MARGIN(6), .NUM_CH(4),
        .CNT_W(33), .LMID(8'd7), .NMID(8'd5), .CFG_BASE(32'h7000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_md(in_md), .in_md_wr(in_md_wr), .out_md_alf(out_md_alf),
        .in_phv(in_phv), .in_phv_wr(in_phv_wr), .out_phv_alf(out_phv_alf),
        .out_md(out_md), .out_md_wr(out_md_wr), .in_md_alf(in_md_alf),
        .out_phv(out_phv), .out_phv_wr(out_phv_wr), .in_phv_alf(in_phv_alf),
        .sent_start(sent_start), .sent_end(sent_end),
        .cin_data(cin_data), .cin_data_wr(cin_data_wr), .cout_ready(cout_ready),
        .cout_data(cout_data), .cout_data_wr(cout_data_wr), .cin_ready(cin_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  id;
        logic [7:0]  proto;
        logic [11:0] len;
        logic [31:0] ts;
        logic        disc;
        logic [7:0]  exp_id;
        logic        exp_disc;
    } pair_vec_t;

    pair_vec_t pv [13];

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int strobe_split = 0;

    logic [255:0]  got_md  [$];
    logic [1023:0] got_phv [$];
    int            got_cyc [$];
    logic [255:0]  exp_md  [$];
    logic [1023:0] exp_phv [$];
    int            exp_cyc [$];
    logic [133:0]  rsp_q   [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_md_wr !== out_phv_wr) strobe_split++;
        if (out_md_wr) begin
            got_md.push_back(out_md);
            got_phv.push_back(out_phv);
            got_cyc.push_back(cyc);
        end
        if (cout_data_wr) rsp_q.push_back(cout_data);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_phv(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            for (int w = 0; w < 32; w++) begin
                if (act[w*32 +: 32] !== exp[w*32 +: 32]) begin
                    $display("FAIL %s: word %0d got %0h, want %0h", name, w,
                             act[w*32 +: 32], exp[w*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [255:0] make_md(input logic [7:0] id, input logic [7:0] proto,
                                             input logic [11:0] len, input logic [31:0] ts,
                                             input logic disc, input logic [31:0] tag);
        logic [255:0] m;
        m = {8{tag ^ 32'h3C3C_0F0F}};
        m[108]    = disc;
        m[107:96] = len;
        m[87:80]  = id;
        m[79:72]  = proto;
        m[31:0]   = ts;
        return m;
    endfunction

    function automatic logic [1023:0] make_phv(input logic [31:0] tag);
        return {32{tag ^ 32'hA5A5_0000}};
    endfunction

    function automatic logic [133:0] cfg_word(input logic [2:0] typ, input int ch,
                                              input logic [3:0] off, input logic [31:0] data);
        logic [31:0] addr;
        addr = 32'h7000_0000 + 32'(16 * ch) + {28'd0, off};
        return {6'h2A, 1'b0, typ, 28'h0C0_FFEE, addr, 32'h1234_5678, data};
    endfunction

    // Drives one pair for a cycle and records the expected output; strobes stay high.
    task automatic send_vec(input pair_vec_t v, input logic [31:0] tag);
        in_md     = make_md(v.id, v.proto, v.len, v.ts, v.disc, tag);
        in_phv    = make_phv(tag);
        in_md_wr  = 1'b1;
        in_phv_wr = 1'b1;
        exp_md.push_back(make_md(v.exp_id, v.proto, v.len, v.ts, v.exp_disc, tag));
        exp_phv.push_back(make_phv(tag));
        exp_cyc.push_back(cyc + 2);
        tick();
    endtask

    task automatic idle_in();
        in_md_wr  = 1'b0;
        in_phv_wr = 1'b0;
    endtask

    task automatic send_table(input int first, input int last);
        for (int i = first; i <= last; i++) send_vec(pv[i], 32'(100 + i));
        idle_in();
        wait_cycles(6);
    endtask

    task automatic compare_out(input string name, input bit timing);
        int n;
        check($sformatf("%s_count", name), 256'(got_md.size()), 256'(exp_md.size()));
        n = (got_md.size() < exp_md.size()) ? got_md.size() : exp_md.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_md[%0d]", name, i), got_md[i], exp_md[i]);
            check_phv($sformatf("%s_phv[%0d]", name, i), got_phv[i], exp_phv[i]);
            if (timing)
                check($sformatf("%s_cycle[%0d]", name, i), 256'(got_cyc[i]), 256'(exp_cyc[i]));
        end
        got_md.delete(); got_phv.delete(); got_cyc.delete();
        exp_md.delete(); exp_phv.delete(); exp_cyc.delete();
    endtask

    task automatic cfg_write(input int ch, input logic [3:0] off, input logic [31:0] data);
        cin_data    = cfg_word(3'b010, ch, off, data);
        cin_data_wr = 1'b1;
        tick();
        cin_data_wr = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [133:0] exp);
        for (int i = 0; i < 4; i++) begin
            if (rsp_q.size() > 0) break;
            tick();
        end
        if (rsp_q.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL %s: no response within 4 cycles, want %0h", name, exp);
        end else begin
            check(name, 256'(rsp_q[0]), 256'(exp));
        end
        rsp_q.delete();
    endtask

    task automatic cfg_read(input string name, input int ch, input logic [3:0] off,
                            input logic [31:0] exp_val);
        logic [133:0] w;
        w = cfg_word(3'b001, ch, off, 32'hDEAD_BEEF);
        rsp_q.delete();
        cin_data    = w;
        cin_data_wr = 1'b1;
        tick();
        cin_data_wr = 1'b0;
        wait_rsp(name, {w[133:128], 4'b1011, w[123:32], exp_val});
    endtask

    task automatic cfg_pass(input string name, input logic [133:0] w);
        rsp_q.delete();
        cin_data    = w;
        cin_data_wr = 1'b1;
        tick();
        cin_data_wr = 1'b0;
        wait_rsp(name, w);
    endtask

    task automatic pulse_start();
        sent_start = 1'b1;
        tick();
        sent_start = 1'b0;
    endtask

    task automatic pulse_end();
        sent_end = 1'b1;
        tick();
        sent_end = 1'b0;
    endtask

    initial begin
        //            id     proto  len       ts             disc  exp_id exp_disc
        pv[0]  = '{8'd7, 8'd6,  12'd100,  32'd10,        1'b0, 8'd5, 1'b0};
        pv[1]  = '{8'd7, 8'd6,  12'd100,  32'd30,        1'b0, 8'd5, 1'b0};
        pv[2]  = '{8'd7, 8'd6,  12'd100,  32'd70,        1'b0, 8'd5, 1'b0};
        pv[3]  = '{8'd7, 8'd6,  12'd100,  32'd100,       1'b0, 8'd5, 1'b0};
        pv[4]  = '{8'd7, 8'd6,  12'd100,  32'd121,       1'b0, 8'd5, 1'b0};
        pv[5]  = '{8'd7, 8'd6,  12'd20,   32'd200,       1'b0, 8'd5, 1'b1};
        pv[6]  = '{8'd7, 8'd17, 12'd20,   32'd210,       1'b0, 8'd5, 1'b0};
        pv[7]  = '{8'd3, 8'd6,  12'd20,   32'd220,       1'b1, 8'd3, 1'b1};
        pv[8]  = '{8'd7, 8'd17, 12'd4095, 32'h0000_0000, 1'b0, 8'd5, 1'b0};
        pv[9]  = '{8'd7, 8'd17, 12'd4095, 32'hFFFF_FFFF, 1'b0, 8'd5, 1'b0};
        pv[10] = '{8'd7, 8'd17, 12'd4095, 32'hFFFF_FFFE, 1'b0, 8'd5, 1'b0};
        pv[11] = '{8'd7, 8'd17, 12'd4095, 32'hFFFF_FFFD, 1'b0, 8'd5, 1'b0};
        pv[12] = '{8'd7, 8'd17, 12'd64,   32'd5,         1'b0, 8'd5, 1'b0};

        rst_n = 1'b0;
        in_md = '0; in_md_wr = 1'b0; in_phv = '0; in_phv_wr = 1'b0;
        in_md_alf = 1'b0; in_phv_alf = 1'b0;
        sent_start = 1'b0; sent_end = 1'b0;
        cin_data = '0; cin_data_wr = 1'b0; cin_ready = 1'b1;
        wait_cycles(3);
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_out_md_wr", 256'(out_md_wr), 256'(0));
        check("rst_out_phv_wr", 256'(out_phv_wr), 256'(0));
        check("rst_cout_wr", 256'(cout_data_wr), 256'(0));
        check("rst_md_alf", 256'(out_md_alf), 256'(0));
        check("rst_phv_alf", 256'(out_phv_alf), 256'(0));
        cfg_read("rst_ch0_status", 0, 4'hE, 32'd0);
        cfg_read("rst_ch0_bytes", 0, 4'h8, 32'd0);

        // Bypass: 10 back-to-back pairs with foreign ID
        for (int i = 0; i < 10; i++) begin
            pair_vec_t b;
            b = '{8'd3, 8'(i), 12'(i * 3), 32'(i * 7), 1'b0, 8'd3, 1'b0};
            send_vec(b, 32'(i));
        end
        idle_in();
        wait_cycles(6);
        compare_out("bypass", 1'b1);

        // Rewrite and count on ch0
        cfg_write(0, 4'h0, 32'd6);
        cfg_write(0, 4'h1, 32'd1);
        cfg_write(0, 4'h2, 32'd50);
        check("wr_no_rsp", 256'(rsp_q.size()), 256'(0));
        pulse_start();
        cfg_read("ch0_status_count", 0, 4'hE, 32'h9);
        send_table(0, 2);
        compare_out("count", 1'b0);
        cfg_read("ch0_bytes_lo", 0, 4'h8, 32'd300);
        cfg_read("ch0_bytes_hi", 0, 4'h9, 32'd0);
        cfg_read("ch0_pkts", 0, 4'hA, 32'd3);
        cfg_read("ch0_time", 0, 4'hC, 32'd60);

        // Window after sent_end (end_time=70, n_rtt=50)
        pulse_end();
        cfg_read("ch0_status_window", 0, 4'hE, 32'hA);
        send_table(3, 4);
        compare_out("window", 1'b0);
        cfg_read("win_pkts", 0, 4'hA, 32'd4);
        cfg_read("win_bytes", 0, 4'h8, 32'd400);
        cfg_read("win_time", 0, 4'hC, 32'd90);
        cfg_read("win_status_done", 0, 4'hE, 32'hB);

        // Discard and multi-channel
        cfg_write(1, 4'h0, 32'd6);
        cfg_write(1, 4'h1, 32'd3);
        cfg_write(2, 4'h0, 32'd6);
        cfg_write(2, 4'h1, 32'd1);
        pulse_start();
        send_table(5, 7);
        compare_out("discard", 1'b0);
        cfg_read("ch1_pkts", 1, 4'hA, 32'd1);
        cfg_read("ch1_bytes", 1, 4'h8, 32'd20);
        cfg_read("ch1_time_first", 1, 4'hC, 32'd0);
        cfg_read("ch2_pkts", 2, 4'hA, 32'd1);
        cfg_read("ch0_pkts_held", 0, 4'hA, 32'd4);

        // Saturation of the 33-bit time counter on ch3
        cfg_write(3, 4'h0, 32'd17);
        cfg_write(3, 4'h1, 32'd1);
        pulse_start();
        send_table(8, 10);
        cfg_read("ch3_time_lo", 3, 4'hC, 32'hFFFF_FFFE);
        cfg_read("ch3_time_hi", 3, 4'hD, 32'd1);
        send_table(11, 11);
        compare_out("sat", 1'b0);
        cfg_read("ch3_time_sat_lo", 3, 4'hC, 32'hFFFF_FFFF);
        cfg_read("ch3_time_sat_hi", 3, 4'hD, 32'd1);
        cfg_read("ch3_pkts", 3, 4'hA, 32'd4);
        cfg_read("ch3_bytes", 3, 4'h8, 32'd16380);

        // Clear in the same cycle as a counted pair
        send_vec(pv[12], 32'd500);
        idle_in();
        cin_data    = cfg_word(3'b010, 3, 4'h1, 32'd5);
        cin_data_wr = 1'b1;
        tick();
        cin_data_wr = 1'b0;
        wait_cycles(4);
        compare_out("clear_pair", 1'b0);
        cfg_read("clr_bytes", 3, 4'h8, 32'd0);
        cfg_read("clr_pkts", 3, 4'hA, 32'd0);
        cfg_read("clr_time_lo", 3, 4'hC, 32'd0);
        cfg_read("clr_time_hi", 3, 4'hD, 32'd0);
        cfg_read("clr_status", 3, 4'hE, 32'h8);

        // Unhandled words pass through unchanged
        cfg_pass("pass_type", cfg_word(3'b100, 0, 4'h0, 32'hCAFE_0001));
        cfg_pass("pass_wr_off5", cfg_word(3'b010, 1, 4'h5, 32'hCAFE_0002));
        cfg_pass("pass_rd_off3", cfg_word(3'b001, 1, 4'h3, 32'hCAFE_0003));
        cfg_pass("pass_out_range", cfg_word(3'b001, 4, 4'h8, 32'hCAFE_0004));

        // Backpressure and almost-full threshold (16 deep, asserts above 10 used)
        in_md_alf = 1'b1;
        tick();
        check("md_alf_pass", 256'(out_md_alf), 256'(1));
        in_md_alf  = 1'b0;
        in_phv_alf = 1'b1;
        tick();
        check("phv_alf_pass", 256'(out_phv_alf), 256'(1));
        check("md_alf_idle", 256'(out_md_alf), 256'(0));
        for (int i = 1; i <= 12; i++) begin
            pair_vec_t b;
            b = '{8'd3, 8'd9, 12'(i), 32'(1000 + i), 1'b0, 8'd3, 1'b0};
            send_vec(b, 32'(600 + i));
            if (i == 10) check("md_alf_at10", 256'(out_md_alf), 256'(0));
            if (i == 11) check("md_alf_at11", 256'(out_md_alf), 256'(1));
        end
        idle_in();
        wait_cycles(7);
        check("bp_no_pop", 256'(got_md.size()), 256'(0));
        in_phv_alf = 1'b0;
        wait_cycles(16);
        compare_out("bp_drain", 1'b0);
        check("md_alf_drained", 256'(out_md_alf), 256'(0));

        // Config read held off by cin_ready
        begin
            logic [133:0] w;
            w = cfg_word(3'b001, 0, 4'hA, 32'd0);
            rsp_q.delete();
            cin_ready   = 1'b0;
            cin_data    = w;
            cin_data_wr = 1'b1;
            wait_cycles(3);
            check("stall_cout_ready", 256'(cout_ready), 256'(0));
            check("stall_no_rsp", 256'(rsp_q.size()), 256'(0));
            cin_ready = 1'b1;
            tick();
            cin_data_wr = 1'b0;
            wait_rsp("stall_rsp", {w[133:128], 4'b1011, w[123:32], 32'd4});
        end

        check("strobe_pairing", 256'(strobe_split), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
